// File: rtl/lte_dl_agc_gain_sched.sv
// lte_dl_agc_gain_sched
//
// Gain scheduler for the eight antenna gains of the LTE downlink TDL AGC path.
// The host programs one target gain code per antenna. Each code is an 8-bit
// db_gain_table index. On every frame head, one sweep steps each applied code
// toward its effective target by at most STEP. Antenna k is stepped on the
// k-th cycle of the sweep. This ramps gain changes instead of letting them
// jump.
//
// Parameters:
//   STEP             maximum code change per antenna per sweep (1..255)
//
// Ports:
//   clk_245          sole clock
//   asy_rst          asynchronous, active-high reset
//   i_fram_hd        frame-head pulse; starts one sweep when idle
//   i_cfg_wr         host write valid (held until accepted)
//   i_cfg_addr       antenna index 0..7 for the write
//   i_cfg_data       target gain code for the write
//   o_cfg_ready      high when idle; a write is taken on i_cfg_wr && o_cfg_ready
//   i_mute           level; forces every effective target to 0
//   i_clr_ovr        clears the sticky overrun flag
//   o_lte_duc_gain1..8  applied gain codes for antennas 0..7, zero-extended
//   o_upd_done       one-cycle pulse after the last antenna of a sweep
//   o_ramp_busy      registered: some applied code differs from its target
//   o_hd_overrun     sticky: a frame head arrived while a sweep was running
module lte_dl_agc_gain_sched #(
  parameter int unsigned STEP = 1
) (
  input  logic        clk_245,
  input  logic        asy_rst,
  input  logic        i_fram_hd,
  input  logic        i_cfg_wr,
  input  logic [2:0]  i_cfg_addr,
  input  logic [7:0]  i_cfg_data,
  output logic        o_cfg_ready,
  input  logic        i_mute,
  input  logic        i_clr_ovr,
  output logic [31:0] o_lte_duc_gain1,
  output logic [31:0] o_lte_duc_gain2,
  output logic [31:0] o_lte_duc_gain3,
  output logic [31:0] o_lte_duc_gain4,
  output logic [31:0] o_lte_duc_gain5,
  output logic [31:0] o_lte_duc_gain6,
  output logic [31:0] o_lte_duc_gain7,
  output logic [31:0] o_lte_duc_gain8,
  output logic        o_upd_done,
  output logic        o_ramp_busy,
  output logic        o_hd_overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [8:0] STEP9 = 9'(STEP);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] tgt_q [8];
  logic [7:0] tgt_d [8];
  logic [7:0] act_q [8];
  logic [7:0] act_d [8];
  logic       ramp_busy_q, ramp_busy_d;
  logic       hd_overrun_q, hd_overrun_d;

  logic       cfgAccept;
  logic [7:0] actCur;
  logic [7:0] effCur;
  logic [8:0] upDiff;
  logic [8:0] dnDiff;
  logic [8:0] upStep;
  logic [8:0] dnStep;
  logic [8:0] upSum;
  logic [8:0] dnSum;
  logic [7:0] actStepped;

  assign cfgAccept = i_cfg_wr && (state_q == IDLE);

  // Step calculation for the antenna selected by cnt_q. Mute is sampled here,
  // in the cycle this antenna is stepped. The arithmetic is 9 bits wide, and
  // the step is clamped to the remaining distance, so a code cannot overshoot
  // its target. The carry/borrow guards on upSum/dnSum are only a safety
  // net; the clamp already keeps them from firing.
  always_comb begin
    actCur = act_q[cnt_q];
    effCur = i_mute ? 8'd0 : tgt_q[cnt_q];
    upDiff = {1'b0, effCur} - {1'b0, actCur};
    dnDiff = {1'b0, actCur} - {1'b0, effCur};
    upStep = (upDiff < STEP9) ? upDiff : STEP9;
    dnStep = (dnDiff < STEP9) ? dnDiff : STEP9;
    upSum  = {1'b0, actCur} + upStep;
    dnSum  = {1'b0, actCur} - dnStep;
    actStepped = actCur;
    if (actCur < effCur) begin
      actStepped = upSum[8] ? 8'hFF : upSum[7:0];
    end else if (actCur > effCur) begin
      actStepped = dnSum[8] ? 8'h00 : dnSum[7:0];
    end
  end

  // Sweep sequencer. A frame head is acted on only in IDLE. The counter
  // walks the antennas 0..7 in UPDATE. DONE lasts one cycle so that the
  // done pulse lines up with the cycle after the last antenna update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_fram_hd) begin
          state_d = UPDATE;
          cnt_d   = 3'd0;
        end
      end
      UPDATE: begin
        if (cnt_q == 3'd7) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Target and applied-code next state. A host write changes only the
  // target. The applied code follows at the next sweep. Mute never touches
  // tgt, so ramping resumes toward the programmed value once mute is dropped.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      tgt_d[k] = tgt_q[k];
      act_d[k] = act_q[k];
    end
    if (cfgAccept) begin
      tgt_d[i_cfg_addr] = i_cfg_data;
    end
    if (state_q == UPDATE) begin
      act_d[cnt_q] = actStepped;
    end
  end

  // Busy is compared against the live effective target every cycle, so a
  // change of mute or a new target shows up one cycle later. It does not
  // wait for a sweep. The overrun flag gives priority to setting over
  // clearing, so a collision on the same edge is not lost.
  always_comb begin
    ramp_busy_d = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (act_q[k] != (i_mute ? 8'd0 : tgt_q[k])) begin
        ramp_busy_d = 1'b1;
      end
    end
    hd_overrun_d = hd_overrun_q;
    if (i_clr_ovr) begin
      hd_overrun_d = 1'b0;
    end
    if (i_fram_hd && (state_q != IDLE)) begin
      hd_overrun_d = 1'b1;
    end
  end

  // State registers. Reset may arrive mid-sweep. It abandons the sweep and
  // clears every code.
  always_ff @(posedge clk_245 or posedge asy_rst) begin
    if (asy_rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      ramp_busy_q  <= 1'b0;
      hd_overrun_q <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        tgt_q[k] <= 8'd0;
        act_q[k] <= 8'd0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ramp_busy_q  <= ramp_busy_d;
      hd_overrun_q <= hd_overrun_d;
      for (int k = 0; k < 8; k++) begin
        tgt_q[k] <= tgt_d[k];
        act_q[k] <= act_d[k];
      end
    end
  end

  assign o_cfg_ready  = (state_q == IDLE);
  assign o_upd_done   = (state_q == DONE);
  assign o_ramp_busy  = ramp_busy_q;
  assign o_hd_overrun = hd_overrun_q;

  // The AGC gain inputs are 32 bits wide, but only the table index is
  // meaningful.
  assign o_lte_duc_gain1 = {24'd0, act_q[0]};
  assign o_lte_duc_gain2 = {24'd0, act_q[1]};
  assign o_lte_duc_gain3 = {24'd0, act_q[2]};
  assign o_lte_duc_gain4 = {24'd0, act_q[3]};
  assign o_lte_duc_gain5 = {24'd0, act_q[4]};
  assign o_lte_duc_gain6 = {24'd0, act_q[5]};
  assign o_lte_duc_gain7 = {24'd0, act_q[6]};
  assign o_lte_duc_gain8 = {24'd0, act_q[7]};

endmodule
